// File: rtl/ast_adc_responder_pkg.sv
// State encoding and channel-select codes for the AST ADC responder.
package ast_adc_responder_pkg;

    typedef enum logic [2:0] {
        StPwrdn   = 3'd0,
        StWakeup  = 3'd1,
        StIdle    = 3'd2,
        StConvert = 3'd3,
        StDone    = 3'd4
    } adc_state_e;

    localparam logic [1:0] SelNone    = 2'b00;
    localparam logic [1:0] SelChn0    = 2'b01;
    localparam logic [1:0] SelChn1    = 2'b10;
    localparam logic [1:0] SelIllegal = 2'b11;

endpackage

// File: rtl/ast_pkg.sv
// Shared AST types for the ADC request/response interface to adc_ctrl.
package ast_pkg;

    localparam int AdcChannels  = 2;
    localparam int AdcDataWidth = 10;

    typedef struct packed {
        logic       pd;
        logic [1:0] channel_sel;
    } adc_ast_req_t;

    typedef struct packed {
        logic [AdcDataWidth-1:0] data;
        logic                    data_valid;
    } adc_ast_rsp_t;

endpackage

// File: rtl/ast_adc_responder_cnt.sv
// Loadable down-counter with a zero flag; load wins over decrement.
module ast_adc_responder_cnt #(
    parameter int Width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [Width-1:0] cnt_r;

    // Counter register: synchronous clear, load on state entry, otherwise count down.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec) begin
            cnt_r <= cnt_r - {{(Width-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == '0);

endmodule

// File: rtl/ast_adc_responder_sva.sv
// Protocol checker for the responder outputs, instantiated alongside the design.
module ast_adc_responder_sva #(
    parameter int ConvCycles = 44
) (
    input logic       clk,
    input logic       rst_n,
    input logic       pd,
    input logic [9:0] data,
    input logic       data_valid,
    input logic       illegal_sel
);

    logic [15:0] pd_low_r;

    // Run length of consecutive cycles with pd sampled low.
    always_ff @(posedge clk) begin
        if (!rst_n || pd) begin
            pd_low_r <= 16'd0;
        end else if (pd_low_r != 16'hFFFF) begin
            pd_low_r <= pd_low_r + 16'd1;
        end else begin
            pd_low_r <= pd_low_r;
        end
    end

    a_known: assert property (@(posedge clk) rst_n |-> !$isunknown({data, data_valid, illegal_sel}));
    a_single: assert property (@(posedge clk) disable iff (!rst_n) data_valid |=> !data_valid);
    a_pd_low: assert property (@(posedge clk) disable iff (!rst_n)
                               data_valid |-> (pd_low_r >= 16'(ConvCycles + 1)));

endmodule

// File: rtl/ast_adc_responder.sv
// ADC front-end model: power-up settling, fixed-latency sample-and-hold conversion,
// registered 10-bit result with a one-cycle valid pulse.
module ast_adc_responder
    import ast_pkg::*;
    import ast_adc_responder_pkg::*;
#(
    parameter int PwrUpCycles = 30,
    parameter int ConvCycles  = 44
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  adc_ast_req_t            adc_i,
    output adc_ast_rsp_t            adc_o,
    input  logic [AdcDataWidth-1:0] chn0_level_i,
    input  logic [AdcDataWidth-1:0] chn1_level_i,
    output logic                    illegal_sel_o
);

    localparam int MaxCycles = (PwrUpCycles > ConvCycles) ? PwrUpCycles : ConvCycles;
    localparam int CntW      = $clog2(MaxCycles + 1);

    adc_state_e              state_r;
    adc_state_e              state_next_s;
    logic [1:0]              chan_r;
    logic [AdcDataWidth-1:0] hold_r;
    logic [AdcDataWidth-1:0] data_r;
    logic                    data_valid_r;
    logic                    illegal_r;
    logic                    pd_s;
    logic [1:0]              sel_s;
    logic                    cnt_load_s;
    logic [CntW-1:0]         cnt_load_val_s;
    logic                    cnt_dec_s;
    logic                    cnt_zero_s;

    assign pd_s  = adc_i.pd;
    assign sel_s = adc_i.channel_sel;

    ast_adc_responder_cnt #(
        .Width (CntW)
    ) u_cnt (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .load     (cnt_load_s),
        .load_val (cnt_load_val_s),
        .dec      (cnt_dec_s),
        .zero     (cnt_zero_s)
    );

    // Next-state and counter control; pd overrides every state.
    always_comb begin
        state_next_s   = state_r;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = '0;
        cnt_dec_s      = 1'b0;
        if (pd_s) begin
            state_next_s = StPwrdn;
        end else begin
            case (state_r)
                StPwrdn: begin
                    state_next_s   = StWakeup;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = CntW'(PwrUpCycles - 1);
                end
                StWakeup: begin
                    if (cnt_zero_s) begin
                        state_next_s = StIdle;
                    end else begin
                        cnt_dec_s = 1'b1;
                    end
                end
                StIdle: begin
                    if ((sel_s == SelChn0) || (sel_s == SelChn1)) begin
                        state_next_s   = StConvert;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = CntW'(ConvCycles - 1);
                    end else begin
                        state_next_s = StIdle;
                    end
                end
                StConvert: begin
                    // Any change of select (including to 00/11) abandons the conversion.
                    if (sel_s != chan_r) begin
                        state_next_s = StIdle;
                    end else if (cnt_zero_s) begin
                        state_next_s = StDone;
                    end else begin
                        cnt_dec_s = 1'b1;
                    end
                end
                StDone: begin
                    state_next_s = StIdle;
                end
                default: begin
                    state_next_s = StPwrdn;
                end
            endcase
        end
    end

    // State, sample-and-hold and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r      <= StPwrdn;
            chan_r       <= SelNone;
            hold_r       <= '0;
            data_r       <= '0;
            data_valid_r <= 1'b0;
            illegal_r    <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            data_valid_r <= (state_next_s == StDone);
            illegal_r    <= !pd_s && (state_r == StIdle) && (sel_s == SelIllegal);
            if ((state_r == StIdle) && (state_next_s == StConvert)) begin
                chan_r <= sel_s;
                hold_r <= (sel_s == SelChn0) ? chn0_level_i : chn1_level_i;
            end
            if (pd_s) begin
                data_r <= '0;
            end else if (state_next_s == StDone) begin
                data_r <= hold_r;
            end
        end
    end

    assign adc_o         = '{data: data_r, data_valid: data_valid_r};
    assign illegal_sel_o = illegal_r;

endmodule

// File: tb/tb_ast_adc_responder.sv
// Directed self-checking bench for ast_adc_responder (PwrUpCycles=4, ConvCycles=6).
module tb_ast_adc_responder;
    import ast_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    adc_ast_req_t adc_i;
    adc_ast_rsp_t adc_o;
    logic [9:0]   chn0_level_i;
    logic [9:0]   chn1_level_i;
    logic         illegal_sel_o;

    int errors = 0;
    int checks = 0;

    ast_adc_responder #(
        .PwrUpCycles (4),
        .ConvCycles  (6)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .adc_i         (adc_i),
        .adc_o         (adc_o),
        .chn0_level_i  (chn0_level_i),
        .chn1_level_i  (chn1_level_i),
        .illegal_sel_o (illegal_sel_o)
    );

    ast_adc_responder_sva #(
        .ConvCycles (6)
    ) u_sva (
        .clk         (clk_i),
        .rst_n       (rst_ni),
        .pd          (adc_i.pd),
        .data        (adc_o.data),
        .data_valid  (adc_o.data_valid),
        .illegal_sel (illegal_sel_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one edge and settle before observing or driving.
    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        adc_i = '{pd: 1'b1, channel_sel: 2'b00};
        chn0_level_i = 10'h000;
        chn1_level_i = 10'h000;
        repeat (3) cycle();
        checks++;
        if (adc_o !== 11'h000 || illegal_sel_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: adc_o=%h illegal=%b, required adc_o=000 illegal=0", adc_o, illegal_sel_o);
        end
        rst_ni = 1'b1;
        cycle();
    endtask

    // Wake-up then first conversion on channel 0; edge k puts the DUT in cycle k+1.
    task automatic test_wakeup_convert();
        adc_i = '{pd: 1'b0, channel_sel: 2'b01};
        chn0_level_i = 10'h155;
        for (int k = 0; k < 15; k++) begin
            cycle();
            checks++;
            if (adc_o.data_valid !== (k == 11)) begin
                errors++;
                $display("FAIL t1_valid edge %0d: got %b, required %b", k, adc_o.data_valid, (k == 11));
            end
            if (k == 11) begin
                checks++;
                if (adc_o.data !== 10'h155) begin
                    errors++;
                    $display("FAIL t1_data: got %h, required 155", adc_o.data);
                end
                adc_i.channel_sel = 2'b00;
            end
        end
    endtask

    task automatic test_sample_hold();
        adc_i.channel_sel = 2'b10;
        chn1_level_i = 10'h2AA;
        for (int k = 0; k < 9; k++) begin
            cycle();
            if (k == 1) chn1_level_i = 10'h001;
            checks++;
            if (adc_o.data_valid !== (k == 6)) begin
                errors++;
                $display("FAIL t2_valid edge %0d: got %b, required %b", k, adc_o.data_valid, (k == 6));
            end
            if (k == 6) adc_i.channel_sel = 2'b00;
        end
        checks++;
        if (adc_o.data !== 10'h2AA) begin
            errors++;
            $display("FAIL t2_data: got %h, required 2aa", adc_o.data);
        end
    endtask

    task automatic test_abort();
        adc_i.channel_sel = 2'b01;
        chn0_level_i = 10'h0F0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (k == 2) adc_i.channel_sel = 2'b00;
            checks++;
            if (adc_o.data_valid !== 1'b0 || adc_o.data !== 10'h2AA) begin
                errors++;
                $display("FAIL t3_abort edge %0d: valid=%b data=%h, required valid=0 data=2aa",
                         k, adc_o.data_valid, adc_o.data);
            end
        end
        adc_i.channel_sel = 2'b01;
        for (int k = 0; k < 8; k++) begin
            cycle();
            checks++;
            if (adc_o.data_valid !== (k == 6)) begin
                errors++;
                $display("FAIL t3_restart edge %0d: got %b, required %b", k, adc_o.data_valid, (k == 6));
            end
            if (k == 6) begin
                checks++;
                if (adc_o.data !== 10'h0F0) begin
                    errors++;
                    $display("FAIL t3_data: got %h, required 0f0", adc_o.data);
                end
                adc_i.channel_sel = 2'b00;
            end
        end
    endtask

    task automatic test_power_down();
        adc_i.channel_sel = 2'b01;
        chn0_level_i = 10'h123;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (k == 2) adc_i.pd = 1'b1;
        end
        checks++;
        if (adc_o.data_valid !== 1'b0 || adc_o.data !== 10'h000) begin
            errors++;
            $display("FAIL t4_pd: valid=%b data=%h, required valid=0 data=000", adc_o.data_valid, adc_o.data);
        end
        adc_i.pd = 1'b0;
        for (int k = 0; k < 13; k++) begin
            cycle();
            checks++;
            if (adc_o.data_valid !== (k == 11)) begin
                errors++;
                $display("FAIL t4_wake edge %0d: got %b, required %b", k, adc_o.data_valid, (k == 11));
            end
            if (k == 11) begin
                checks++;
                if (adc_o.data !== 10'h123) begin
                    errors++;
                    $display("FAIL t4_data: got %h, required 123", adc_o.data);
                end
                adc_i.channel_sel = 2'b00;
            end
        end
    endtask

    task automatic test_illegal_sel();
        adc_i.channel_sel = 2'b11;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (k == 2) adc_i.channel_sel = 2'b00;
            checks++;
            if (illegal_sel_o !== (k < 3) || adc_o.data_valid !== 1'b0 || adc_o.data !== 10'h123) begin
                errors++;
                $display("FAIL t5_illegal edge %0d: illegal=%b valid=%b data=%h, required illegal=%b valid=0 data=123",
                         k, illegal_sel_o, adc_o.data_valid, adc_o.data, (k < 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_data;
        adc_i.channel_sel = 2'b01;
        chn0_level_i = 10'h3C3;
        exp_data = 10'h3C3;
        for (int k = 0; k < 23; k++) begin
            cycle();
            checks++;
            if (adc_o.data_valid !== (k == 6 || k == 14 || k == 22)) begin
                errors++;
                $display("FAIL t6_valid edge %0d: got %b", k, adc_o.data_valid);
            end
            if (k == 6 || k == 14 || k == 22) begin
                checks++;
                if (adc_o.data !== exp_data) begin
                    errors++;
                    $display("FAIL t6_data edge %0d: got %h, required %h", k, adc_o.data, exp_data);
                end
            end
            if (k == 6) begin
                chn0_level_i = 10'h05A;
                exp_data = 10'h05A;
            end
            if (k == 14) begin
                chn0_level_i = 10'h1E1;
                exp_data = 10'h1E1;
            end
            if (k == 22) adc_i.channel_sel = 2'b00;
        end
    endtask

    task automatic test_reset_mid_convert();
        adc_i.channel_sel = 2'b01;
        chn0_level_i = 10'h2F0;
        for (int k = 0; k < 3; k++) begin
            cycle();
        end
        rst_ni = 1'b0;
        cycle();
        checks++;
        if (adc_o !== 11'h000 || illegal_sel_o !== 1'b0) begin
            errors++;
            $display("FAIL t6_rst: adc_o=%h illegal=%b, required adc_o=000 illegal=0", adc_o, illegal_sel_o);
        end
        rst_ni = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            checks++;
            if (adc_o.data_valid !== 1'b0) begin
                errors++;
                $display("FAIL t6_discard edge %0d: got valid %b, required 0", k, adc_o.data_valid);
            end
        end
        adc_i.channel_sel = 2'b00;
    endtask

    initial begin
        test_reset();
        test_wakeup_convert();
        test_sample_hold();
        test_abort();
        test_power_down();
        test_illegal_sel();
        test_back_to_back();
        test_reset_mid_convert();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
